// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one dot-product job over the mac datapath.
// Issues consecutive operand-buffer reads, feeds the running accumulator back
// as the mac psum one cycle later (buffer read latency), captures each mac
// result, and returns the final sum through a valid/ready handshake.
module mac_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_busy,
    output logic              o_err,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [1:0]        o_mac_mode,
    output logic [23:0]       o_mac_psum,
    input  logic [23:0]       i_mac_result,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [23:0]       o_result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ILLEGAL = 2'd3;

    state_t            state, state_nxt;
    logic [1:0]        mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [23:0]       acc_q;
    logic              err_q;
    logic              dv_q;     // read data valid: rd_en delayed by the buffer latency

    logic accept;
    logic reject;
    logic last_issue;

    assign accept     = (state == S_IDLE) && i_start && (i_mode != MODE_ILLEGAL);
    assign reject     = (state == S_IDLE) && i_start && (i_mode == MODE_ILLEGAL);
    assign last_issue = (cnt_q == len_q - LEN_W'(1));

    // Next-state selection; i_start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = (i_len == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (last_issue)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE: begin
                if (i_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register plus job context, read pointer and accumulator.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= S_IDLE;
            mode_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            acc_q  <= '0;
            err_q  <= 1'b0;
            dv_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= reject;
            dv_q  <= (state == S_RUN);

            if (accept) begin
                mode_q <= i_mode;
                len_q  <= i_len;
                addr_q <= i_base_addr;
                cnt_q  <= '0;
                acc_q  <= '0;
            end

            // Address wraps naturally at 2^ADDR_W.
            if (state == S_RUN) begin
                addr_q <= addr_q + ADDR_W'(1);
                cnt_q  <= cnt_q + LEN_W'(1);
            end

            // Mode returns to 0 together with the return to IDLE.
            if (state == S_DONE && i_ready)
                mode_q <= '0;

            // No saturation here; the mac owns any clamping.
            if (dv_q)
                acc_q <= i_mac_result;
        end
    end

    // Output decode: gate psum/address/result so they read 0 when not meaningful.
    always_comb begin
        o_busy     = (state != S_IDLE);
        o_err      = err_q;
        o_rd_en    = 1'b0;
        o_rd_addr  = '0;
        o_mac_mode = mode_q;
        o_mac_psum = '0;
        o_valid    = 1'b0;
        o_result   = '0;
        if (state == S_RUN) begin
            o_rd_en   = 1'b1;
            o_rd_addr = addr_q;
        end
        if (dv_q)
            o_mac_psum = acc_q;
        if (state == S_DONE) begin
            o_valid  = 1'b1;
            o_result = acc_q;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed scenarios plus random jobs,
// checked against a job-level model (expected addresses and a running sum).
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  len;
    logic [7:0]  base;
    logic        busy, err, rd_en, valid, ready;
    logic [7:0]  rd_addr;
    logic [1:0]  mac_mode;
    logic [23:0] mac_psum, mac_result, result;

    int tests = 0;
    int fails = 0;

    // Operand contents per address; mac model adds the chunk value to psum.
    logic [23:0] data [256];
    logic [7:0]  rd_addr_d;

    always #5 clk = ~clk;

    mac_seq_ctrl #(.ADDR_W(8), .LEN_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_len(len),
        .i_base_addr(base), .o_busy(busy), .o_err(err), .o_rd_en(rd_en),
        .o_rd_addr(rd_addr), .o_mac_mode(mac_mode), .o_mac_psum(mac_psum),
        .i_mac_result(mac_result), .o_valid(valid), .i_ready(ready), .o_result(result)
    );

    // Operand buffer with one-cycle read latency feeding a mac that adds.
    always @(posedge clk) rd_addr_d <= rd_addr;
    assign mac_result = mac_psum + data[rd_addr_d];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " busy"},  {31'd0, busy},  0);
        chk({tag, " err"},   {31'd0, err},   0);
        chk({tag, " rd_en"}, {31'd0, rd_en}, 0);
        chk({tag, " valid"}, {31'd0, valid}, 0);
        chk({tag, " addr"},  {24'd0, rd_addr}, 0);
        chk({tag, " mmode"}, {30'd0, mac_mode}, 0);
        chk({tag, " psum"},  {8'd0, mac_psum}, 0);
        chk({tag, " result"}, {8'd0, result}, 0);
    endtask

    // Model: job of n chunks at base b sums data[b+k mod 256]; reads occupy
    // cycles 1..n, psum in cycle c is the sum of the first c-2 chunks,
    // result valid at cycle n+2 (cycle 1 when n == 0).
    task automatic run_job(input string tag, input int m, input int n, input int b,
                           input int rdy_wait, input bit pulse_start);
        logic [23:0] part;
        logic [23:0] total;
        total = '0;
        for (int k = 0; k < n; k++) total = total + data[(b + k) % 256];

        start = 1'b1; mode = 2'(m); len = 8'(n); base = 8'(b);
        step();
        start = 1'b0;
        part = '0;
        for (int c = 1; c <= n + 1 && n > 0; c++) begin
            chk({tag, " busy"},  {31'd0, busy},  1);
            chk({tag, " valid"}, {31'd0, valid}, 0);
            chk({tag, " mmode"}, {30'd0, mac_mode}, 32'(m));
            chk({tag, " rd_en"}, {31'd0, rd_en}, (c <= n) ? 1 : 0);
            chk({tag, " addr"},  {24'd0, rd_addr}, (c <= n) ? 32'((b + c - 1) % 256) : 0);
            chk({tag, " psum"},  {8'd0, mac_psum}, (c >= 2) ? {8'd0, part} : 0);
            if (c >= 2) part = part + data[(b + c - 2) % 256];
            step();
        end
        chk({tag, " valid"},  {31'd0, valid}, 1);
        chk({tag, " result"}, {8'd0, result}, {8'd0, total});
        chk({tag, " mmode"},  {30'd0, mac_mode}, 32'(m));
        chk({tag, " rd_en"},  {31'd0, rd_en}, 0);
        for (int w = 0; w < rdy_wait; w++) begin
            start = pulse_start; mode = 2'd0; len = 8'd2;
            step();
            chk({tag, " hold valid"},  {31'd0, valid}, 1);
            chk({tag, " hold result"}, {8'd0, result}, {8'd0, total});
            chk({tag, " hold rd_en"},  {31'd0, rd_en}, 0);
        end
        ready = 1'b1; start = pulse_start;
        step();
        ready = 1'b0; start = 1'b0;
        chk({tag, " post valid"}, {31'd0, valid}, 0);
        chk({tag, " post busy"},  {31'd0, busy},  0);
        chk({tag, " post mmode"}, {30'd0, mac_mode}, 0);
        step();
        chk({tag, " idle busy"},  {31'd0, busy},  0);
        chk({tag, " idle rd_en"}, {31'd0, rd_en}, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = '0; len = '0; base = '0; ready = 1'b0;
        for (int i = 0; i < 256; i++) data[i] = 24'($urandom);
        step();
        step();
        chk_idle_outputs("reset");
        rst = 1'b0;
        step();
        chk_idle_outputs("post-reset");

        // T1: each chunk contributes 5.
        for (int i = 16; i < 19; i++) data[i] = 24'd5;
        run_job("T1", 0, 3, 'h10, 0, 1'b0);

        // T2: empty job.
        run_job("T2", 1, 0, 'h33, 2, 1'b0);

        // T3: address wrap.
        run_job("T3", 2, 4, 'hFE, 0, 1'b0);

        // T4: consumer stalls, starts in DONE ignored.
        run_job("T4", 1, 5, 'h40, 5, 1'b1);

        // T5: illegal mode rejected.
        start = 1'b1; mode = 2'd3; len = 8'd4; base = 8'h20;
        step();
        start = 1'b0;
        chk("T5 err",   {31'd0, err},   1);
        chk("T5 busy",  {31'd0, busy},  0);
        chk("T5 rd_en", {31'd0, rd_en}, 0);
        step();
        chk("T5 err clr", {31'd0, err},  0);
        chk("T5 busy2",   {31'd0, busy}, 0);

        // T6: reset in the middle of a job.
        start = 1'b1; mode = 2'd0; len = 8'd8; base = 8'h80;
        step();
        start = 1'b0;
        step();
        chk("T6 running", {31'd0, rd_en}, 1);
        rst = 1'b1;
        step();
        chk_idle_outputs("T6 abort");
        rst = 1'b0;
        step();
        chk_idle_outputs("T6 quiet");
        run_job("T6 fresh", 2, 1, 'h07, 0, 1'b0);

        // Random jobs.
        for (int j = 0; j < 12; j++) begin
            run_job("rand", int'($urandom_range(0, 2)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
